convert_k_stream: RTL and testbench



---
 rtl/convert_k_stream_pkg.sv | 27 ++
 rtl/convert_k_stream.sv | 101 ++++++++++
 tb/tb_convert_k_stream.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/convert_k_stream_pkg.sv
// Shared definitions for the binary-pixel streaming converters.
// Latency: n/a (types, constants and an elaboration-time helper only).
// Backpressure: n/a.
//
// Contents: default K_ONE/K_ZERO word constants, the 2-state emitter
// encoding, and a clog2 helper that never returns less than 1 so that
// derived index/counter widths stay legal for degenerate sizes.
package convert_k_stream_pkg;

  localparam logic [31:0] K_ONE_DEF  = 32'h0080_0000;
  localparam logic [31:0] K_ZERO_DEF = 32'h0000_0000;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) begin
      r = r + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/convert_k_stream.sv
// Buffers CH-pixel binary beats and emits one DWIDTH-bit word per pixel, LSB pixel first.
// Latency: first word valid the cycle after the accepting edge; 1 word/cycle sustained.
// Backpressure: words held stable while out_ready is low; in_ready only on the final slot.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   input beat handshake; in_bits (bit 0 first), in_inv sampled with beat
//   out_valid/out_ready output word handshake; out_data is K_ONE or K_ZERO
//   out_idx, out_last   pixel position in frame, high on pixel NPIX-1
//   frame_done          one-cycle pulse after the out_last word is accepted
module convert_k_stream
  import convert_k_stream_pkg::*;
#(
  parameter int                 DWIDTH = 32,
  parameter int                 CH     = 8,
  parameter int                 NPIX   = 784,
  parameter logic [DWIDTH-1:0]  K_ONE  = DWIDTH'(K_ONE_DEF),
  parameter logic [DWIDTH-1:0]  K_ZERO = DWIDTH'(K_ZERO_DEF),
  parameter int                 IDXW   = clog2_min1(NPIX)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CH-1:0]     in_bits,
  input  logic              in_inv,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_data,
  output logic [IDXW-1:0]   out_idx,
  output logic              out_last,
  output logic              frame_done
);

  // Slot counter must hold the value CH itself.
  localparam int SW = clog2_min1(CH + 1);

  state_t          state;
  logic [CH-1:0]   shreg;
  logic [SW-1:0]   slots;
  logic [IDXW-1:0] pix_cnt;
  logic [IDXW-1:0] pix_nxt;
  logic [SW-1:0]   load_slots;
  logic            out_fire;
  logic            in_fire;
  logic            last_slot;

  assign out_valid = (state == EMIT);
  assign out_data  = shreg[0] ? K_ONE : K_ZERO;
  assign out_idx   = pix_cnt;
  assign out_last  = (pix_cnt == IDXW'(NPIX - 1));

  assign last_slot = (slots == SW'(1));
  // A new beat may only land when the register is empty or its final
  // pixel leaves this same cycle, which keeps back-to-back beats bubble-free.
  assign in_ready  = !rst && ((state == IDLE) || (out_ready && last_slot));
  assign out_fire  = out_valid && out_ready;
  assign in_fire   = in_valid && in_ready;

  // Pixel position after this cycle's output handshake; a beat loaded in
  // the same cycle is sized against this, not the stale count.
  always_comb begin
    pix_nxt = pix_cnt;
    if (out_fire) begin
      pix_nxt = out_last ? '0 : pix_cnt + IDXW'(1);
    end
  end

  // Emit at most the pixels left in the frame; any surplus bits of a beat
  // straddling the frame end are simply never shifted out.
  always_comb begin
    int rem;
    rem = NPIX - int'(pix_nxt);
    load_slots = (rem < CH) ? SW'(rem) : SW'(CH);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      shreg      <= '0;
      slots      <= '0;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_fire && out_last;
      if (out_fire) begin
        pix_cnt <= pix_nxt;
        shreg   <= shreg >> 1;
        slots   <= slots - SW'(1);
      end
      if (in_fire) begin
        shreg <= in_bits ^ {CH{in_inv}};
        slots <= load_slots;
        state <= EMIT;
      end else if (out_fire && last_slot) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_convert_k_stream.sv
module tb_convert_k_stream;

  localparam logic [31:0] K1 = 32'h0080_0000;
  localparam logic [31:0] K0 = 32'h0000_0000;
  localparam int          NP = 20;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_bits;
  logic        in_inv;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_idx;
  logic        out_last;
  logic        frame_done;

  int n_checks = 0;
  int n_fail   = 0;

  convert_k_stream #(
    .DWIDTH(32),
    .CH(8),
    .NPIX(NP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_bits(in_bits),
    .in_inv(in_inv),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_idx(out_idx),
    .out_last(out_last),
    .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected word at pixel position idx carrying (post-inversion) value b.
  task automatic chk_word(input string name, input int idx, input logic b);
    check({name, " valid"}, {31'd0, out_valid}, 32'd1);
    check({name, " data"}, out_data, b ? K1 : K0);
    check({name, " idx"}, {27'd0, out_idx}, idx);
    check({name, " last"}, {31'd0, out_last}, {31'd0, (idx == NP - 1)});
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    logic [7:0] bits;
    logic       inv;
    logic [0:7] order;  // expected pixel values in emission order
    int         idx0;
    int         n;
  } vec_t;

  vec_t vecs[5];
  logic [0:15] seq16;
  int n_vld;

  initial begin
    // NPIX=20: beats land at 0, 8, 16 (only 4 pixels), then wrap to 0.
    vecs[0] = '{8'b1010_0110, 1'b0, 8'b0110_0101, 0,  8};
    vecs[1] = '{8'b1010_0110, 1'b1, 8'b1001_1010, 8,  8};
    vecs[2] = '{8'b1111_0001, 1'b0, 8'b1000_1111, 16, 4};
    vecs[3] = '{8'b0000_0001, 1'b1, 8'b0111_1111, 0,  8};
    vecs[4] = '{8'b1100_0011, 1'b0, 8'b1100_0011, 8,  8};

    in_bits = '0;
    in_inv  = 1'b0;
    rst     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst in_ready", {31'd0, in_ready}, 32'd0);
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst out_data", out_data, K0);
    check("rst out_idx", {27'd0, out_idx}, 32'd0);
    check("rst out_last", {31'd0, out_last}, 32'd0);
    check("rst frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;
    #1;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven beats through one frame and into the next.
    for (int v = 0; v < 5; v++) begin
      in_valid = 1'b1;
      in_bits  = vecs[v].bits;
      in_inv   = vecs[v].inv;
      #1;
      check($sformatf("v%0d accept rdy", v), {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      in_inv   = ~in_inv;      // must not affect the buffered beat
      in_bits  = ~in_bits;
      for (int k = 0; k < vecs[v].n; k++) begin
        chk_word($sformatf("v%0d w%0d", v, k), vecs[v].idx0 + k, vecs[v].order[k]);
        @(negedge clk);
      end
      check($sformatf("v%0d drained", v), {31'd0, out_valid}, 32'd0);
      check($sformatf("v%0d frame_done", v), {31'd0, frame_done},
            {31'd0, (vecs[v].idx0 + vecs[v].n == NP)});
      if (vecs[v].idx0 + vecs[v].n == NP) begin
        @(negedge clk);
        check("frame_done pulse end", {31'd0, frame_done}, 32'd0);
      end
    end

    // Stall at word 2 for three cycles.
    do_reset();
    in_valid = 1'b1;
    in_bits  = 8'b1010_0110;
    in_inv   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        out_ready = 1'b0;
        for (int s = 0; s < 3; s++) begin
          #1;
          chk_word($sformatf("stall%0d", s), 2, 1'b1);
          check($sformatf("stall%0d in_ready", s), {31'd0, in_ready}, 32'd0);
          @(negedge clk);
        end
        out_ready = 1'b1;
      end
      chk_word($sformatf("stall w%0d", k), k, vecs[0].order[k]);
      @(negedge clk);
    end
    check("stall drained", {31'd0, out_valid}, 32'd0);

    // Two beats back-to-back: 16 words in 16 cycles, no bubble.
    do_reset();
    seq16    = 16'b0000_1111_0101_1010;
    in_valid = 1'b1;
    in_bits  = 8'hF0;
    in_inv   = 1'b0;
    @(negedge clk);
    n_vld = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 0) in_bits = 8'h5A;
      if (i == 8) in_valid = 1'b0;
      #1;
      if (i == 0) check("b2b rdy busy", {31'd0, in_ready}, 32'd0);
      if (i == 7) check("b2b rdy last slot", {31'd0, in_ready}, 32'd1);
      if (out_valid) n_vld++;
      chk_word($sformatf("b2b w%0d", i), i, seq16[i]);
      @(negedge clk);
    end
    check("b2b valid count", n_vld, 32'd16);
    check("b2b drained", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a beat.
    do_reset();
    in_valid = 1'b1;
    in_bits  = 8'hFF;
    in_inv   = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      chk_word($sformatf("mid w%0d", k), k, 1'b1);
      @(negedge clk);
    end
    rst = 1'b1;
    @(negedge clk);
    check("mid-rst out_valid", {31'd0, out_valid}, 32'd0);
    check("mid-rst out_idx", {27'd0, out_idx}, 32'd0);
    check("mid-rst out_data", out_data, K0);
    check("mid-rst in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b0;
    in_valid = 1'b1;
    in_bits  = 8'h02;
    #1;
    check("mid-rst rdy after", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    chk_word("mid new w0", 0, 1'b0);
    @(negedge clk);
    chk_word("mid new w1", 1, 1'b1);
    repeat (8) @(negedge clk);
    check("mid final drained", {31'd0, out_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
